// File: rtl/rst_sequencer_if.sv
// Reset-sequencer bus: processor soft-reset request in, staged domain resets and
// reset bookkeeping out.
interface rst_sequencer_if;
  logic       soft_rst_req;
  logic       rst_periph;
  logic       rst_cpu;
  logic       ready;
  logic [1:0] rst_cause;
  logic [7:0] soft_cnt;

  modport master (
    output soft_rst_req,
    input  rst_periph,
    input  rst_cpu,
    input  ready,
    input  rst_cause,
    input  soft_cnt
  );

  modport slave (
    input  soft_rst_req,
    output rst_periph,
    output rst_cpu,
    output ready,
    output rst_cause,
    output soft_cnt
  );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset release: stretch the incoming reset, free peripherals first, then the
// CPU; replays on a soft request from RUN and records cause and soft-reset count.
module rst_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic          clk,
  input  logic          rst,
  rst_sequencer_if.slave bus
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [1:0] CAUSE_HARD = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    GAP  = 2'b01,
    RUN  = 2'b10
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    sat_inc8 = (value == 8'hFF) ? 8'hFF : (value + 8'd1);
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             hold_done_s;
  logic             gap_done_s;

  logic             rst_periph_r, rst_periph_s;
  logic             rst_cpu_r,    rst_cpu_s;
  logic             ready_r,      ready_s;
  logic [1:0]       rst_cause_r,  rst_cause_s;
  logic [7:0]       soft_cnt_r,   soft_cnt_s;

  assign hold_done_s = (cnt_r == HOLD_LAST);
  assign gap_done_s  = (cnt_r == GAP_LAST);

  // State, counter and registered outputs; rst overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HOLD;
      cnt_r        <= '0;
      rst_periph_r <= 1'b1;
      rst_cpu_r    <= 1'b1;
      ready_r      <= 1'b0;
      rst_cause_r  <= CAUSE_HARD;
      soft_cnt_r   <= 8'h00;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      rst_periph_r <= rst_periph_s;
      rst_cpu_r    <= rst_cpu_s;
      ready_r      <= ready_s;
      rst_cause_r  <= rst_cause_s;
      soft_cnt_r   <= soft_cnt_s;
    end
  end

  // Next state and stage counter.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      HOLD: begin
        if (hold_done_s) begin
          next_state_s = GAP;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_done_s) begin
          next_state_s = RUN;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.soft_rst_req) begin
          next_state_s = HOLD;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = '0;
        end
      end
      default: begin
        next_state_s = HOLD;
        next_cnt_s   = '0;
      end
    endcase
  end

  // Next output values; the domain resets are fully decided by state so a corrupted
  // register self-heals on the following edge.
  always_comb begin
    rst_periph_s = 1'b1;
    rst_cpu_s    = 1'b1;
    ready_s      = 1'b0;
    rst_cause_s  = rst_cause_r;
    soft_cnt_s   = soft_cnt_r;
    case (state_r)
      HOLD: begin
        if (hold_done_s) begin
          rst_periph_s = 1'b0;
        end else begin
          rst_periph_s = 1'b1;
        end
      end
      GAP: begin
        rst_periph_s = 1'b0;
        if (gap_done_s) begin
          rst_cpu_s = 1'b0;
          ready_s   = 1'b1;
        end else begin
          rst_cpu_s = 1'b1;
          ready_s   = 1'b0;
        end
      end
      RUN: begin
        if (bus.soft_rst_req) begin
          rst_cause_s = CAUSE_SOFT;
          soft_cnt_s  = sat_inc8(soft_cnt_r);
        end else begin
          rst_periph_s = 1'b0;
          rst_cpu_s    = 1'b0;
          ready_s      = 1'b1;
        end
      end
      default: begin
        rst_periph_s = 1'b1;
        rst_cpu_s    = 1'b1;
        ready_s      = 1'b0;
      end
    endcase
  end

  assign bus.rst_periph = rst_periph_r;
  assign bus.rst_cpu    = rst_cpu_r;
  assign bus.ready      = ready_r;
  assign bus.rst_cause  = rst_cause_r;
  assign bus.soft_cnt   = soft_cnt_r;

endmodule
